spi_stabilizer: RTL and testbench
=================================

SPI_STABILIZER -- requirements
Module: SpiStabilizer

Interface
REQ-001 Parameter REQUIRED_CLOCKS, default 74, is the number of consecutive qualifying SPI clock edges needed to declare the link initialized (valid range 1..2^CNT_WIDTH-1).
REQ-002 Parameter CNT_WIDTH, default 7, is the width of the qualifying-edge counter.
REQ-003 Port CLK, input, 1 bit: the single clock (SPI SCLK); all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port MOSI, input, 1 bit: SPI host data line.
REQ-006 Port CS, input, 1 bit: SPI chip-select line, sampled as a level (high = deselected).
REQ-007 Port IsInitialized, output, 1 bit, registered: high once the power-up clock sequence is recognised.
REQ-008 Port ClockCount, output, CNT_WIDTH bits: current counter value; present only under the Configuration macro.

Function
REQ-009 A qualifying edge is a rising CLK edge with CS==1 and MOSI==1 both sampled at that edge.
REQ-010 While IsInitialized==0, each qualifying edge increments the counter by 1.
REQ-011 While IsInitialized==0, any non-qualifying edge (CS==0 or MOSI==0) clears the counter to 0 on that edge; there is no partial credit.
REQ-012 On the qualifying edge where the counter goes from REQUIRED_CLOCKS-1 to REQUIRED_CLOCKS, IsInitialized goes to 1 on the same edge, with no extra latency.
REQ-013 After IsInitialized becomes 1, the counter saturates at REQUIRED_CLOCKS and never wraps.
REQ-014 After IsInitialized becomes 1, it is sticky: it stays 1 regardless of CS and MOSI until reset.
REQ-015 If reset and a qualifying edge occur on the same CLK edge, reset wins.
REQ-016 There is no combinational path from inputs to IsInitialized.
REQ-017 The counter never exceeds REQUIRED_CLOCKS.

Reset
REQ-018 On a rising CLK edge with reset==1, the counter is set to 0 and IsInitialized to 0.
REQ-019 A reset asserted mid-sequence or after initialization restarts detection from zero; the first post-reset qualifying edge counts as 1.
REQ-020 Before the first reset edge, output values are unspecified; benches shall apply reset with at least one CLK edge before checking outputs.

Configuration
REQ-021 Macro SPI_STABILIZER_COUNT_OUT_EN: when defined, ClockCount is a module port driven by the internal counter.
REQ-022 When SPI_STABILIZER_COUNT_OUT_EN is undefined, ClockCount does not exist and the port list is exactly CLK, reset, MOSI, CS, IsInitialized.
REQ-023 All other behaviour is identical with and without SPI_STABILIZER_COUNT_OUT_EN.

Verification
REQ-024 Reset, then 100 edges with CS=0, MOSI=0 -> IsInitialized=0 throughout, count=0.
REQ-025 Continue with 40 edges CS=1, MOSI=1 -> count=40, IsInitialized=0; then 1 edge CS=0, MOSI=1 -> count=0, IsInitialized=0.
REQ-026 Continue with 90 edges CS=1, MOSI=1 -> IsInitialized rises exactly at the 74th edge of that run, then holds 1 through edge 90 with count saturated at 74.
REQ-027 Reset, 73 qualifying edges, then 1 edge with MOSI=0, then 73 qualifying edges -> IsInitialized=0 throughout; the 74th further qualifying edge sets it to 1.
REQ-028 After initialization, drive CS=0, MOSI=0 for 10 edges -> IsInitialized stays 1; assert reset for 1 edge -> IsInitialized=0 and count=0 immediately after that edge.
REQ-029 Build with REQUIRED_CLOCKS=1 -> the first qualifying edge after reset sets IsInitialized=1.

Source files
------------

// File: rtl/spi_stabilizer.sv
// SPI power-up clock detector: counts consecutive SCLK edges with CS and MOSI high.
// Define SPI_STABILIZER_COUNT_OUT_EN to expose the qualifying-edge counter as ClockCount.
module spi_stabilizer #(
    parameter int REQUIRED_CLOCKS = 74,
    parameter int CNT_WIDTH       = 7
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic                 MOSI,
    input  logic                 CS,
`ifdef SPI_STABILIZER_COUNT_OUT_EN
    output logic [CNT_WIDTH-1:0] ClockCount,
`endif
    output logic                 IsInitialized
);

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(REQUIRED_CLOCKS - 1);

    typedef enum logic {
        ST_WAIT = 1'b0,
        ST_INIT = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 qualify;

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= ST_WAIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Once initialized the counter simply holds, which leaves it saturated at REQUIRED_CLOCKS.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        qualify = CS & MOSI;
        if (state_q == ST_WAIT) begin
            if (qualify) begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_INIT;
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    assign IsInitialized = (state_q == ST_INIT);

`ifdef SPI_STABILIZER_COUNT_OUT_EN
    assign ClockCount = cnt_q;
`endif

endmodule

// File: tb/tb_spi_stabilizer.sv
// Directed bench for spi_stabilizer (default 74-edge instance plus a REQUIRED_CLOCKS=1 instance).
module tb_spi_stabilizer;

    logic       CLK;
    logic       reset;
    logic       MOSI;
    logic       CS;
    logic       init_a;
    logic       init_b;
    int         checks;
    int         errors;
`ifdef SPI_STABILIZER_COUNT_OUT_EN
    logic [6:0] count_a;
    logic [6:0] count_b;
`endif

    spi_stabilizer #(.REQUIRED_CLOCKS(74), .CNT_WIDTH(7)) u_dut (
        .CLK           (CLK),
        .reset         (reset),
        .MOSI          (MOSI),
        .CS            (CS),
`ifdef SPI_STABILIZER_COUNT_OUT_EN
        .ClockCount    (count_a),
`endif
        .IsInitialized (init_a)
    );

    spi_stabilizer #(.REQUIRED_CLOCKS(1), .CNT_WIDTH(7)) u_dut_one (
        .CLK           (CLK),
        .reset         (reset),
        .MOSI          (MOSI),
        .CS            (CS),
`ifdef SPI_STABILIZER_COUNT_OUT_EN
        .ClockCount    (count_b),
`endif
        .IsInitialized (init_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic check_count(input string tag, input int exp);
`ifdef SPI_STABILIZER_COUNT_OUT_EN
        check_val(tag, 32'(count_a), 32'(exp));
`else
        check_val(tag, 32'(init_a), 32'(exp >= 74));
`endif
    endtask

    // One CLK edge: inputs change on the falling edge, outputs sampled 1 time unit after the rising edge.
    task automatic tick(input logic r, input logic cs, input logic mosi);
        @(negedge CLK);
        reset = r;
        CS    = cs;
        MOSI  = mosi;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        CS     = 1'b0;
        MOSI   = 1'b0;

        tick(1'b1, 1'b0, 1'b0);
        check_val("rst_init", 32'(init_a), 32'd0);
        check_val("rst_init_one", 32'(init_b), 32'd0);
        check_count("rst_count", 0);

        for (int i = 1; i <= 100; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            check_val("idle_init", 32'(init_a), 32'd0);
        end
        check_count("idle_count", 0);
        check_val("idle_init_one", 32'(init_b), 32'd0);

        for (int i = 1; i <= 40; i++) begin
            tick(1'b0, 1'b1, 1'b1);
            check_val("run40_init", 32'(init_a), 32'd0);
            if (i == 1) check_val("one_first_edge", 32'(init_b), 32'd1);
        end
        check_count("run40_count", 40);

        tick(1'b0, 1'b0, 1'b1);
        check_val("cs_low_init", 32'(init_a), 32'd0);
        check_count("cs_low_count", 0);
        check_val("one_sticky", 32'(init_b), 32'd1);

        for (int i = 1; i <= 90; i++) begin
            tick(1'b0, 1'b1, 1'b1);
            check_val("run90_init", 32'(init_a), 32'(i >= 74));
            check_count("run90_count", (i < 74) ? i : 74);
        end

        tick(1'b1, 1'b0, 1'b0);
        check_val("rst2_init", 32'(init_a), 32'd0);
        check_val("rst2_init_one", 32'(init_b), 32'd0);
        check_count("rst2_count", 0);

        for (int i = 1; i <= 73; i++) begin
            tick(1'b0, 1'b1, 1'b1);
            check_val("pre73_init", 32'(init_a), 32'd0);
        end
        check_count("pre73_count", 73);
        tick(1'b0, 1'b1, 1'b0);
        check_val("mosi_low_init", 32'(init_a), 32'd0);
        check_count("mosi_low_count", 0);
        for (int i = 1; i <= 73; i++) begin
            tick(1'b0, 1'b1, 1'b1);
            check_val("post73_init", 32'(init_a), 32'd0);
        end
        tick(1'b0, 1'b1, 1'b1);
        check_val("edge74_init", 32'(init_a), 32'd1);
        check_count("edge74_count", 74);

        for (int i = 1; i <= 10; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            check_val("sticky_init", 32'(init_a), 32'd1);
        end
        check_count("sticky_count", 74);

        tick(1'b1, 1'b1, 1'b1);
        check_val("rst_win_init", 32'(init_a), 32'd0);
        check_val("rst_win_init_one", 32'(init_b), 32'd0);
        check_count("rst_win_count", 0);

        tick(1'b0, 1'b1, 1'b1);
        check_val("post_rst_init", 32'(init_a), 32'd0);
        check_val("post_rst_init_one", 32'(init_b), 32'd1);
`ifdef SPI_STABILIZER_COUNT_OUT_EN
        check_val("post_rst_count", 32'(count_a), 32'd1);
        check_val("one_sat_count", 32'(count_b), 32'd1);
        tick(1'b0, 1'b1, 1'b1);
        check_val("one_no_wrap", 32'(count_b), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
